// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid buffer, synchronous flush
// that inserts a BUBBLE word, and a saturating back-pressure cycle counter.
module pipe_stage_skid #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cycles
);

  // State bits are {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_fire, out_fire;

  assign out_valid    = state_q[1];
  assign in_ready     = ~state_q[0];
  assign out_data     = main_data_q;
  assign stall_cycles = stall_q;

  assign in_fire  = in_valid & ~state_q[0];
  assign out_fire = state_q[1] & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = BUBBLE;
      skid_data_d = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = FULL;
            main_data_d = in_data;
          end
        end
        FULL: begin
          if (out_fire && in_fire) begin
            main_data_d = in_data;
          end else if (out_fire) begin
            state_d     = EMPTY;
            main_data_d = BUBBLE;
          end else if (in_fire) begin
            state_d     = SKID;
            skid_data_d = in_data;
          end
        end
        SKID: begin
          // Skid entry moves forward only; new data cannot overtake it.
          if (out_fire) begin
            state_d     = FULL;
            main_data_d = skid_data_q;
            skid_data_d = BUBBLE;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = BUBBLE;
          skid_data_d = BUBBLE;
        end
      endcase
    end
  end

  // Counter ignores flush; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (state_q[1] && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= BUBBLE;
      skid_data_q <= BUBBLE;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

endmodule
